wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Sequences the single register-file write port in the writeback stage between two sources: ALU results and variable-latency data-memory load returns.
- Drives the writeback mux inputs (data_mem, data_alu, MemToReg_m) plus the register write enable and destination.
- Buffers ALU results while a load return owns the port, and stalls the M stage when the buffer is full or a write-after-write hazard exists against the outstanding load.

Parameters:
- DATA_W, 32, data width of ALU results and load data.
- REG_AW, 5, register address width.
- BUF_DEPTH, 2, ALU result buffer entries (power of two, at least 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alu_valid_m  in  1  ALU result offered this cycle
- alu_rd_m  in  REG_AW  ALU destination register
- alu_data_m  in  DATA_W  ALU result
- ld_issue_m  in  1  load issued to data memory this cycle
- ld_rd_m  in  REG_AW  load destination register
- mem_rvalid  in  1  load data returned (one cycle pulse; cannot be back-pressured)
- mem_rdata  in  DATA_W  load data
- stall_m  out  1  M stage must hold; alu_valid_m is not accepted
- ld_busy  out  1  one load outstanding; no new load may issue
- reg_write_w  out  1  register file write enable
- write_rd_w  out  REG_AW  register file write address
- MemToReg_m  out  1  mux select: 1 = data_mem, 0 = data_alu
- data_mem  out  DATA_W  load data to the mux
- data_alu  out  DATA_W  ALU data to the mux
- protocol_err  out  1  sticky protocol violation flag

Behaviour:
- Reset: every output is 0. The buffer is emptied, the pending load is cleared and protocol_err clears. Reset mid-operation discards buffered results and any outstanding load; a mem_rvalid arriving after reset counts as unexpected.
- Load tracking:
  - ld_issue_m while ld_busy=0 sets ld_busy=1 next cycle and latches ld_rd_m.
  - ld_issue_m while ld_busy=1 is ignored and sets protocol_err.
  - mem_rvalid while ld_busy=0 is ignored and sets protocol_err.
- stall_m is combinational: stall_m = (count == BUF_DEPTH) OR (alu_valid_m AND ld_busy AND alu_rd_m == pending_rd AND alu_rd_m != 0).
- ALU accept = alu_valid_m AND NOT stall_m. Count does not account for a same-cycle pop; a full buffer stalls for one cycle even while popping.
- Port selection each cycle (priority order):
  - (1) mem_rvalid AND ld_busy: load wins. Next cycle reg_write_w=1, MemToReg_m=1, write_rd_w=pending_rd, data_mem=mem_rdata. ld_busy clears next cycle.
  - (2) buffer non-empty: pop head. Next cycle reg_write_w=1, MemToReg_m=0, write_rd_w and data_alu come from the head entry.
  - (3) buffer empty and ALU accepted: bypass. Next cycle writes alu_rd_m/alu_data_m with MemToReg_m=0.
  - (4) otherwise next cycle reg_write_w=0.
- Buffer push: an accepted ALU result is pushed unless it was bypassed in (3). In-order FIFO: ALU results retire in acceptance order. Push and pop in the same cycle leaves count unchanged.
- Same-cycle load issue and load return: a return with ld_busy=1 retires the old load. A simultaneous ld_issue_m is then accepted, so ld_busy stays 1 with the new rd.
- Writes to register 0 (either source) are forced to reg_write_w=0 but still consume their port cycle.
- Write latency: exactly 1 cycle from selection to reg_write_w.
- Idle hold: data_mem holds its value on ALU writes and idle cycles; data_alu holds on load writes and idle cycles. MemToReg_m holds its last value when reg_write_w=0.
- Throughput: one register write per cycle maximum.

Test Plan:
- Single ALU result alu_rd_m=3, data=102, buffer empty, no load -> next cycle reg_write_w=1, write_rd_w=3, MemToReg_m=0, data_alu=102.
- Load rd=5 issued, mem_rvalid with 43 two cycles later -> ld_busy=1 meanwhile; then reg_write_w=1, rd=5, MemToReg_m=1, data_mem=43; ld_busy=0.
- mem_rvalid coincident with ALU results rd=7 (344) and next cycle rd=8 (343) -> load written first. Results 344 then 343 follow in order on the next two cycles. stall_m=1 for one cycle when count reaches 2.
- Load rd=9 pending, ALU result rd=9 offered -> stall_m=1 until the cycle of mem_rvalid. The ALU write to r9 lands after the load write.
- ALU result rd=0 -> reg_write_w=0 for that slot. mem_rvalid with no load pending -> protocol_err=1 and it stays set.
- Assert rst with 2 buffered results and a load pending -> all outputs 0 next cycle. A later mem_rvalid produces no write and sets protocol_err.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between ALU results
// and variable-latency load returns, buffering ALU results while a load owns the port.
`default_nettype none

module wb_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid_m,
  input  logic [REG_AW-1:0] alu_rd_m,
  input  logic [DATA_W-1:0] alu_data_m,
  input  logic              ld_issue_m,
  input  logic [REG_AW-1:0] ld_rd_m,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_m,
  output logic              ld_busy,
  output logic              reg_write_w,
  output logic [REG_AW-1:0] write_rd_w,
  output logic              MemToReg_m,
  output logic [DATA_W-1:0] data_mem,
  output logic [DATA_W-1:0] data_alu,
  output logic              protocol_err
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUF_DEPTH);

  logic [DATA_W-1:0] fifo_data [BUF_DEPTH];
  logic [REG_AW-1:0] fifo_rd   [BUF_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [REG_AW-1:0] pending_rd;

  logic              ld_ret;
  logic              alu_accept;
  logic              fifo_empty;
  logic              pop;
  logic              bypass;
  logic              push;
  logic              sel_valid;
  logic              sel_mem;
  logic [REG_AW-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              write_en;

  // Full-buffer stall ignores a same-cycle pop to keep stall_m off the pop path.
  assign stall_m = (count == FULL_COUNT) ||
                   (alu_valid_m && ld_busy && (alu_rd_m == pending_rd) && (alu_rd_m != '0));

  always_comb begin
    ld_ret     = mem_rvalid && ld_busy;
    alu_accept = alu_valid_m && !stall_m;
    fifo_empty = (count == '0);
    pop        = !ld_ret && !fifo_empty;
    bypass     = !ld_ret && fifo_empty && alu_accept;
    push       = alu_accept && !bypass;

    sel_valid = 1'b0;
    sel_mem   = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (ld_ret) begin
      sel_valid = 1'b1;
      sel_mem   = 1'b1;
      sel_rd    = pending_rd;
      sel_data  = mem_rdata;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_rd    = fifo_rd[head];
      sel_data  = fifo_data[head];
    end else if (bypass) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd_m;
      sel_data  = alu_data_m;
    end
    // r0 writes still burn their slot but look like an idle cycle downstream.
    write_en = sel_valid && (sel_rd != '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[tail] <= alu_data_m;
      fifo_rd[tail]   <= alu_rd_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      ld_busy      <= 1'b0;
      pending_rd   <= '0;
      protocol_err <= 1'b0;
      reg_write_w  <= 1'b0;
      write_rd_w   <= '0;
      MemToReg_m   <= 1'b0;
      data_mem     <= '0;
      data_alu     <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // A returning load frees the tracker in time to accept a same-cycle issue.
      if (ld_ret) begin
        ld_busy <= ld_issue_m;
        if (ld_issue_m) pending_rd <= ld_rd_m;
      end else if (ld_issue_m && !ld_busy) begin
        ld_busy    <= 1'b1;
        pending_rd <= ld_rd_m;
      end

      if ((ld_issue_m && ld_busy && !ld_ret) || (mem_rvalid && !ld_busy))
        protocol_err <= 1'b1;

      reg_write_w <= write_en;
      if (write_en) begin
        write_rd_w <= sel_rd;
        MemToReg_m <= sel_mem;
        if (sel_mem) data_mem <= sel_data;
        else         data_alu <= sel_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios plus a randomized run against a queue-based
// reference model of the writeback port arbiter.
`default_nettype none

module tb_wb_port_arbiter;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid_m;
  logic [REG_AW-1:0] alu_rd_m;
  logic [DATA_W-1:0] alu_data_m;
  logic              ld_issue_m;
  logic [REG_AW-1:0] ld_rd_m;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_m;
  logic              ld_busy;
  logic              reg_write_w;
  logic [REG_AW-1:0] write_rd_w;
  logic              MemToReg_m;
  logic [DATA_W-1:0] data_mem;
  logic [DATA_W-1:0] data_alu;
  logic              protocol_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(DATA_W), .REG_AW(REG_AW), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_m(alu_valid_m), .alu_rd_m(alu_rd_m), .alu_data_m(alu_data_m),
    .ld_issue_m(ld_issue_m), .ld_rd_m(ld_rd_m),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_m(stall_m), .ld_busy(ld_busy),
    .reg_write_w(reg_write_w), .write_rd_w(write_rd_w), .MemToReg_m(MemToReg_m),
    .data_mem(data_mem), .data_alu(data_alu), .protocol_err(protocol_err)
  );

  // Reference model: in-order queue of accepted ALU results plus one load tracker.
  typedef struct {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;
  ent_t              q[$];
  logic              m_busy, m_err, e_rw, e_m2r;
  logic [REG_AW-1:0] m_rd, e_rd;
  logic [DATA_W-1:0] e_dm, e_da;

  task automatic idle();
    alu_valid_m = 1'b0; alu_rd_m = '0; alu_data_m = '0;
    ld_issue_m = 1'b0; ld_rd_m = '0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    n_tests++;
    if ({stall_m, ld_busy, reg_write_w, write_rd_w, MemToReg_m, data_mem, data_alu, protocol_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rw=%b rd=%0d m2r=%b dm=%0d da=%0d err=%b busy=%b stall=%b, want all 0",
               reg_write_w, write_rd_w, MemToReg_m, data_mem, data_alu, protocol_err, ld_busy, stall_m);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu_bypass();
    do_reset();
    alu_valid_m = 1'b1; alu_rd_m = 5'd3; alu_data_m = 32'd102;
    #1;
    n_tests++;
    if (stall_m !== 1'b0) begin n_fail++; $display("FAIL bypass_stall: got %b want 0", stall_m); end
    tick();
    idle();
    n_tests++;
    if ({reg_write_w, write_rd_w, MemToReg_m, data_alu} !== {1'b1, 5'd3, 1'b0, 32'd102}) begin
      n_fail++;
      $display("FAIL bypass_write: rw=%b rd=%0d m2r=%b da=%0d want 1/3/0/102", reg_write_w, write_rd_w, MemToReg_m, data_alu);
    end
    tick();
    n_tests++;
    if (reg_write_w !== 1'b0) begin n_fail++; $display("FAIL bypass_idle: rw=%b want 0", reg_write_w); end
  endtask

  task automatic test_load();
    do_reset();
    ld_issue_m = 1'b1; ld_rd_m = 5'd5;
    tick();
    idle();
    n_tests++;
    if ({ld_busy, reg_write_w} !== 2'b10) begin n_fail++; $display("FAIL load_busy1: busy=%b rw=%b want 1/0", ld_busy, reg_write_w); end
    tick();
    n_tests++;
    if (ld_busy !== 1'b1) begin n_fail++; $display("FAIL load_busy2: busy=%b want 1", ld_busy); end
    mem_rvalid = 1'b1; mem_rdata = 32'd43;
    tick();
    idle();
    n_tests++;
    if ({reg_write_w, write_rd_w, MemToReg_m, data_mem, ld_busy} !== {1'b1, 5'd5, 1'b1, 32'd43, 1'b0}) begin
      n_fail++;
      $display("FAIL load_write: rw=%b rd=%0d m2r=%b dm=%0d busy=%b want 1/5/1/43/0",
               reg_write_w, write_rd_w, MemToReg_m, data_mem, ld_busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ld_issue_m = 1'b1; ld_rd_m = 5'd6;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'd77; ld_issue_m = 1'b1; ld_rd_m = 5'd10;
    alu_valid_m = 1'b1; alu_rd_m = 5'd7; alu_data_m = 32'd344;
    #1;
    n_tests++;
    if (stall_m !== 1'b0) begin n_fail++; $display("FAIL b2b_stall0: got %b want 0", stall_m); end
    tick();
    n_tests++;
    if ({reg_write_w, write_rd_w, MemToReg_m, data_mem, ld_busy} !== {1'b1, 5'd6, 1'b1, 32'd77, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_load1: rw=%b rd=%0d m2r=%b dm=%0d busy=%b want 1/6/1/77/1",
               reg_write_w, write_rd_w, MemToReg_m, data_mem, ld_busy);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'd55; ld_issue_m = 1'b0;
    alu_valid_m = 1'b1; alu_rd_m = 5'd8; alu_data_m = 32'd343;
    tick();
    idle();
    #1;
    n_tests++;
    if ({reg_write_w, write_rd_w, MemToReg_m, data_mem, stall_m} !== {1'b1, 5'd10, 1'b1, 32'd55, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_load2_full: rw=%b rd=%0d m2r=%b dm=%0d stall=%b want 1/10/1/55/1",
               reg_write_w, write_rd_w, MemToReg_m, data_mem, stall_m);
    end
    tick();
    n_tests++;
    if ({reg_write_w, write_rd_w, MemToReg_m, data_alu, data_mem, stall_m} !== {1'b1, 5'd7, 1'b0, 32'd344, 32'd55, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_alu1: rw=%b rd=%0d m2r=%b da=%0d dm=%0d stall=%b want 1/7/0/344/55/0",
               reg_write_w, write_rd_w, MemToReg_m, data_alu, data_mem, stall_m);
    end
    tick();
    n_tests++;
    if ({reg_write_w, write_rd_w, MemToReg_m, data_alu} !== {1'b1, 5'd8, 1'b0, 32'd343}) begin
      n_fail++;
      $display("FAIL b2b_alu2: rw=%b rd=%0d m2r=%b da=%0d want 1/8/0/343", reg_write_w, write_rd_w, MemToReg_m, data_alu);
    end
    tick();
    n_tests++;
    if ({reg_write_w, MemToReg_m, data_alu} !== {1'b0, 1'b0, 32'd343}) begin
      n_fail++;
      $display("FAIL b2b_hold: rw=%b m2r=%b da=%0d want 0/0/343", reg_write_w, MemToReg_m, data_alu);
    end
  endtask

  task automatic test_waw_hazard();
    do_reset();
    ld_issue_m = 1'b1; ld_rd_m = 5'd9;
    tick();
    idle();
    alu_valid_m = 1'b1; alu_rd_m = 5'd9; alu_data_m = 32'd900;
    #1;
    n_tests++;
    if (stall_m !== 1'b1) begin n_fail++; $display("FAIL waw_stall1: got %b want 1", stall_m); end
    tick();
    n_tests++;
    if ({stall_m, reg_write_w} !== 2'b10) begin n_fail++; $display("FAIL waw_stall2: stall=%b rw=%b want 1/0", stall_m, reg_write_w); end
    mem_rvalid = 1'b1; mem_rdata = 32'd11;
    #1;
    n_tests++;
    if (stall_m !== 1'b1) begin n_fail++; $display("FAIL waw_stall_ret: got %b want 1", stall_m); end
    tick();
    mem_rvalid = 1'b0;
    #1;
    n_tests++;
    if ({reg_write_w, write_rd_w, MemToReg_m, data_mem, stall_m} !== {1'b1, 5'd9, 1'b1, 32'd11, 1'b0}) begin
      n_fail++;
      $display("FAIL waw_load: rw=%b rd=%0d m2r=%b dm=%0d stall=%b want 1/9/1/11/0",
               reg_write_w, write_rd_w, MemToReg_m, data_mem, stall_m);
    end
    tick();
    idle();
    n_tests++;
    if ({reg_write_w, write_rd_w, MemToReg_m, data_alu} !== {1'b1, 5'd9, 1'b0, 32'd900}) begin
      n_fail++;
      $display("FAIL waw_alu: rw=%b rd=%0d m2r=%b da=%0d want 1/9/0/900", reg_write_w, write_rd_w, MemToReg_m, data_alu);
    end
  endtask

  task automatic test_reg0_and_err();
    do_reset();
    alu_valid_m = 1'b1; alu_rd_m = 5'd0; alu_data_m = 32'd5;
    tick();
    idle();
    n_tests++;
    if ({reg_write_w, protocol_err} !== 2'b00) begin n_fail++; $display("FAIL reg0_write: rw=%b err=%b want 0/0", reg_write_w, protocol_err); end
    mem_rvalid = 1'b1; mem_rdata = 32'd66;
    tick();
    idle();
    n_tests++;
    if ({reg_write_w, protocol_err} !== 2'b01) begin n_fail++; $display("FAIL spurious_rvalid: rw=%b err=%b want 0/1", reg_write_w, protocol_err); end
    tick();
    tick();
    n_tests++;
    if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", protocol_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ld_issue_m = 1'b1; ld_rd_m = 5'd4;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'd1; ld_issue_m = 1'b1; ld_rd_m = 5'd12;
    alu_valid_m = 1'b1; alu_rd_m = 5'd1; alu_data_m = 32'd21;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'd2; ld_issue_m = 1'b1; ld_rd_m = 5'd13;
    alu_valid_m = 1'b1; alu_rd_m = 5'd2; alu_data_m = 32'd22;
    tick();
    idle();
    #1;
    n_tests++;
    if ({ld_busy, stall_m} !== 2'b11) begin n_fail++; $display("FAIL midrst_setup: busy=%b stall=%b want 1/1", ld_busy, stall_m); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({stall_m, ld_busy, reg_write_w, write_rd_w, MemToReg_m, data_mem, data_alu, protocol_err} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: rw=%b rd=%0d m2r=%b dm=%0d da=%0d err=%b busy=%b stall=%b, want all 0",
               reg_write_w, write_rd_w, MemToReg_m, data_mem, data_alu, protocol_err, ld_busy, stall_m);
    end
    tick();
    n_tests++;
    if (reg_write_w !== 1'b0) begin n_fail++; $display("FAIL midrst_discard: rw=%b want 0", reg_write_w); end
    mem_rvalid = 1'b1; mem_rdata = 32'd99;
    tick();
    idle();
    n_tests++;
    if ({reg_write_w, protocol_err} !== 2'b01) begin n_fail++; $display("FAIL midrst_late_rvalid: rw=%b err=%b want 0/1", reg_write_w, protocol_err); end
  endtask

  task automatic test_random();
    logic exp_stall, last_stall, ret, wrote, w_mem;
    logic [REG_AW-1:0] w_rd;
    logic [DATA_W-1:0] w_data;
    ent_t e;
    for (int blk = 0; blk < 3; blk++) begin
      do_reset();
      q.delete();
      m_busy = 1'b0; m_rd = '0; m_err = 1'b0;
      e_rw = 1'b0; e_rd = '0; e_m2r = 1'b0; e_dm = '0; e_da = '0;
      last_stall = 1'b0;
      for (int cyc = 0; cyc < 250; cyc++) begin
        // A stalled ALU offer is held, as a real M stage would.
        if (!(alu_valid_m && last_stall)) begin
          alu_valid_m = ($urandom_range(0, 2) != 0);
          alu_rd_m    = REG_AW'($urandom_range(0, 7));
          alu_data_m  = $urandom;
        end
        mem_rvalid = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 79) == 0);
        mem_rdata  = $urandom;
        ld_issue_m = (!m_busy || mem_rvalid) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
        ld_rd_m    = REG_AW'($urandom_range(0, 7));
        exp_stall  = (q.size() == DEPTH) ||
                     (alu_valid_m && m_busy && alu_rd_m == m_rd && alu_rd_m != '0);
        #1;
        n_tests++;
        if ({stall_m, ld_busy} !== {exp_stall, m_busy}) begin
          n_fail++;
          $display("FAIL rand_stall cyc=%0d: stall=%b busy=%b want %b/%b", cyc, stall_m, ld_busy, exp_stall, m_busy);
        end
        last_stall = exp_stall;

        ret   = mem_rvalid && m_busy;
        wrote = 1'b0; w_mem = 1'b0; w_rd = '0; w_data = '0;
        if (ret) begin
          wrote = 1'b1; w_mem = 1'b1; w_rd = m_rd; w_data = mem_rdata;
        end
        if (alu_valid_m && !exp_stall) begin
          e.rd = alu_rd_m; e.data = alu_data_m;
          q.push_back(e);
        end
        if (!ret && q.size() > 0) begin
          e = q.pop_front();
          wrote = 1'b1; w_rd = e.rd; w_data = e.data;
        end
        if ((ld_issue_m && m_busy && !ret) || (mem_rvalid && !m_busy)) m_err = 1'b1;
        if (ret) begin
          m_busy = ld_issue_m;
          if (ld_issue_m) m_rd = ld_rd_m;
        end else if (ld_issue_m && !m_busy) begin
          m_busy = 1'b1; m_rd = ld_rd_m;
        end
        e_rw = wrote && (w_rd != '0);
        if (e_rw) begin
          e_rd = w_rd; e_m2r = w_mem;
          if (w_mem) e_dm = w_data;
          else       e_da = w_data;
        end

        tick();
        n_tests++;
        if ({reg_write_w, write_rd_w, MemToReg_m, data_mem, data_alu, protocol_err} !==
            {e_rw, e_rd, e_m2r, e_dm, e_da, m_err}) begin
          n_fail++;
          $display("FAIL rand_write blk=%0d cyc=%0d: rw=%b rd=%0d m2r=%b dm=%h da=%h err=%b want %b/%0d/%b/%h/%h/%b",
                   blk, cyc, reg_write_w, write_rd_w, MemToReg_m, data_mem, data_alu, protocol_err,
                   e_rw, e_rd, e_m2r, e_dm, e_da, m_err);
        end
      end
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_alu_bypass();
    test_load();
    test_back_to_back();
    test_waw_hazard();
    test_reg0_and_err();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
